// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared types and helpers for the synchronous FIFO controller and its consumers.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// FIFO handshake bundle: the producer/consumer side drives via master, the FIFO sits on slave.
interface sync_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = fifo_pkg::fifo_cnt_w(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents not reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store on accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, threshold flags, read-mode mux and
// sticky error flags around a fifo_ram storage array.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int         WIDTH  = 8,
  parameter int         DEPTH  = 16,
  parameter fifo_mode_e MODE   = FIFO_STD,
  parameter int         AF_LVL = DEPTH - 2,
  parameter int         AE_LVL = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_ctrl: AF_LVL must be in 1..DEPTH");
  end
  if ((AE_LVL < 0) || (AE_LVL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_ctrl: AE_LVL must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] rd_data;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc;

  // Flush masks both requests so nothing is stored or popped in the flush cycle.
  assign wr_acc = bus.wr_en & ~bus.full  & ~bus.flush;
  assign rd_acc = bus.rd_en & ~bus.empty & ~bus.flush;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointer, occupancy, registered read data and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (rd_acc && (MODE == FIFO_STD)) dout_q <= rd_data;
      if (bus.wr_en && bus.full)  ovf_q <= 1'b1;
      if (bus.rd_en && bus.empty) unf_q <= 1'b1;
    end
  end

  assign bus.count        = cnt_q;
  assign bus.full         = (cnt_q == CW'(DEPTH));
  assign bus.empty        = (cnt_q == '0);
  assign bus.almost_full  = (cnt_q >= CW'(AF_LVL));
  assign bus.almost_empty = (cnt_q <= CW'(AE_LVL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // FWFT shows the head word directly; STD presents the word captured on the last read.
  assign bus.data_out = (MODE == FIFO_FWFT) ? (bus.empty ? '0 : rd_data) : dout_q;
endmodule
